// File: rtl/lfm_phase_accum_gen.sv
// DDS phase/frequency accumulator producing a burst of CW or LFM pulses as sine-ROM addresses.
// Optional LFM_PHASE_DITHER_EN adds an LFSR dither below the address bits before truncation.
module lfm_phase_accum_gen #(
   parameter int PHASE_W  = 32,
   parameter int ADDR_W   = 12,
   parameter int CNT_W    = 27,
   parameter int NIMP_W   = 5,
   parameter int DITHER_W = 8
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [1:0]          SIGNAL_MODE,
   input  logic [PHASE_W-1:0]  FREQ_START,
   input  logic [PHASE_W-1:0]  FREQ_STEP,
   input  logic [CNT_W-1:0]    IMP_SAMPLES,
   input  logic [CNT_W-1:0]    PERIOD_SAMPLES,
   input  logic [NIMP_W-1:0]   NUM_OF_IMP,
   input  logic                SIGN_START_GEN,
   input  logic                ABORT,
   input  logic                OUT_REG_READY,
   output logic [ADDR_W-1:0]   ROM_ADDRESS,
   output logic                SAMPLE_VALID,
   output logic                GATE,
   output logic                SIGN_START_CALC,
   output logic                SIGN_STOP_CALC,
   output logic                BUSY,
   output logic                CFG_ERR
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state_reg, state_next;
   logic [1:0]          mode_reg, mode_next;
   logic [PHASE_W-1:0]  freq_start_reg, freq_start_next;
   logic [PHASE_W-1:0]  freq_step_reg, freq_step_next;
   logic [CNT_W-1:0]    imp_reg, imp_next;
   logic [CNT_W-1:0]    period_reg, period_next;
   logic [NIMP_W-1:0]   nimp_reg, nimp_next;
   logic [PHASE_W-1:0]  phase_reg, phase_next;
   logic [PHASE_W-1:0]  freq_reg, freq_next;
   logic [CNT_W-1:0]    k_reg, k_next;
   logic [NIMP_W-1:0]   pulse_reg, pulse_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic                valid_reg, valid_next;
   logic                gate_reg, gate_next;
   logic                start_calc_reg, start_calc_next;
   logic                stop_calc_reg, stop_calc_next;
   logic                busy_reg, busy_next;
   logic                cfg_err_reg, cfg_err_next;

   logic                advance;
   logic                in_pulse;
   logic                last_sample;
   logic                period_end;
   logic [ADDR_W-1:0]   pulse_addr;

`ifdef LFM_PHASE_DITHER_EN
   // Galois right-shift feedback masks for maximal-length sequences
   function automatic logic [31:0] lfsr_mask(input int w);
      case (w)
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         10:      return 32'h0000_0240;
         12:      return 32'h0000_0E08;
         16:      return 32'h0000_B400;
         default: return 32'h0000_00B8;
      endcase
   endfunction

   localparam logic [DITHER_W-1:0] LFSR_MASK = DITHER_W'(lfsr_mask(DITHER_W));
   localparam int DITHER_SHIFT = PHASE_W - ADDR_W - DITHER_W;

   logic [DITHER_W-1:0] lfsr_reg;
   logic [PHASE_W-1:0]  dither_phase;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         lfsr_reg <= DITHER_W'(1);
      else
         lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_MASK : '0);
   end

   assign dither_phase = phase_reg + (PHASE_W'(lfsr_reg) << DITHER_SHIFT);
   assign pulse_addr   = dither_phase[PHASE_W-1 -: ADDR_W];
`else
   assign pulse_addr   = phase_reg[PHASE_W-1 -: ADDR_W];
`endif

   assign advance     = !valid_reg || OUT_REG_READY;
   assign in_pulse    = k_reg < imp_reg;
   assign last_sample = (pulse_reg == nimp_reg - NIMP_W'(1)) && (k_reg == imp_reg - CNT_W'(1));
   assign period_end  = k_reg == period_reg - CNT_W'(1);

   always_comb begin
      state_next      = state_reg;
      mode_next       = mode_reg;
      freq_start_next = freq_start_reg;
      freq_step_next  = freq_step_reg;
      imp_next        = imp_reg;
      period_next     = period_reg;
      nimp_next       = nimp_reg;
      phase_next      = phase_reg;
      freq_next       = freq_reg;
      k_next          = k_reg;
      pulse_next      = pulse_reg;
      addr_next       = addr_reg;
      valid_next      = valid_reg;
      gate_next       = gate_reg;
      start_calc_next = start_calc_reg;
      stop_calc_next  = stop_calc_reg;
      busy_next       = busy_reg;
      cfg_err_next    = 1'b0;

      if (ABORT) begin
         state_next      = IDLE;
         mode_next       = '0;
         freq_start_next = '0;
         freq_step_next  = '0;
         imp_next        = '0;
         period_next     = '0;
         nimp_next       = '0;
         phase_next      = '0;
         freq_next       = '0;
         k_next          = '0;
         pulse_next      = '0;
         addr_next       = '0;
         valid_next      = 1'b0;
         gate_next       = 1'b0;
         start_calc_next = 1'b0;
         stop_calc_next  = 1'b0;
         busy_next       = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (SIGN_START_GEN) begin
                  mode_next       = SIGNAL_MODE;
                  freq_start_next = FREQ_START;
                  freq_step_next  = FREQ_STEP;
                  imp_next        = IMP_SAMPLES;
                  period_next     = (PERIOD_SAMPLES > IMP_SAMPLES) ? PERIOD_SAMPLES : IMP_SAMPLES;
                  nimp_next       = NUM_OF_IMP;
                  if (IMP_SAMPLES == '0 || NUM_OF_IMP == '0) begin
                     cfg_err_next = 1'b1;
                  end else begin
                     state_next = LOAD;
                     busy_next  = 1'b1;
                  end
               end
            end
            LOAD: begin
               phase_next = '0;
               freq_next  = freq_start_reg;
               k_next     = '0;
               pulse_next = '0;
               state_next = RUN;
            end
            RUN: begin
               if (advance) begin
                  if (valid_reg && stop_calc_reg) begin
                     // final sample has just been accepted
                     state_next      = IDLE;
                     addr_next       = '0;
                     valid_next      = 1'b0;
                     gate_next       = 1'b0;
                     start_calc_next = 1'b0;
                     stop_calc_next  = 1'b0;
                     busy_next       = 1'b0;
                  end else begin
                     valid_next      = 1'b1;
                     gate_next       = in_pulse;
                     addr_next       = in_pulse ? pulse_addr : '0;
                     start_calc_next = (pulse_reg == '0) && (k_reg == '0);
                     stop_calc_next  = last_sample;
                     if (in_pulse) begin
                        phase_next = phase_reg + freq_reg;
                        case (mode_reg)
                           2'd1:    freq_next = freq_reg + freq_step_reg;
                           2'd2:    freq_next = freq_reg - freq_step_reg;
                           2'd3:    freq_next = (k_reg < (imp_reg >> 1)) ? freq_reg + freq_step_reg
                                                                         : freq_reg - freq_step_reg;
                           default: freq_next = freq_reg;
                        endcase
                     end
                     // each pulse restarts phase and frequency coherently
                     if (period_end) begin
                        k_next     = '0;
                        phase_next = '0;
                        freq_next  = freq_start_reg;
                        pulse_next = pulse_reg + NIMP_W'(1);
                     end else begin
                        k_next = k_reg + CNT_W'(1);
                     end
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg      <= IDLE;
         mode_reg       <= '0;
         freq_start_reg <= '0;
         freq_step_reg  <= '0;
         imp_reg        <= '0;
         period_reg     <= '0;
         nimp_reg       <= '0;
         phase_reg      <= '0;
         freq_reg       <= '0;
         k_reg          <= '0;
         pulse_reg      <= '0;
         addr_reg       <= '0;
         valid_reg      <= 1'b0;
         gate_reg       <= 1'b0;
         start_calc_reg <= 1'b0;
         stop_calc_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         cfg_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mode_reg       <= mode_next;
         freq_start_reg <= freq_start_next;
         freq_step_reg  <= freq_step_next;
         imp_reg        <= imp_next;
         period_reg     <= period_next;
         nimp_reg       <= nimp_next;
         phase_reg      <= phase_next;
         freq_reg       <= freq_next;
         k_reg          <= k_next;
         pulse_reg      <= pulse_next;
         addr_reg       <= addr_next;
         valid_reg      <= valid_next;
         gate_reg       <= gate_next;
         start_calc_reg <= start_calc_next;
         stop_calc_reg  <= stop_calc_next;
         busy_reg       <= busy_next;
         cfg_err_reg    <= cfg_err_next;
      end
   end

   assign ROM_ADDRESS     = addr_reg;
   assign SAMPLE_VALID    = valid_reg;
   assign GATE            = gate_reg;
   assign SIGN_START_CALC = start_calc_reg;
   assign SIGN_STOP_CALC  = stop_calc_reg;
   assign BUSY            = busy_reg;
   assign CFG_ERR         = cfg_err_reg;

endmodule

// File: tb/tb_lfm_phase_accum_gen.sv
// Bench for lfm_phase_accum_gen: directed vector table, corner sequences and randomized
// bursts checked against an arithmetic model of the pulse train.
module tb_lfm_phase_accum_gen;

   localparam int PW = 32;
   localparam int AW = 12;
   localparam int CW = 27;
   localparam int NW = 5;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic [1:0]    SIGNAL_MODE = '0;
   logic [PW-1:0] FREQ_START = '0;
   logic [PW-1:0] FREQ_STEP = '0;
   logic [CW-1:0] IMP_SAMPLES = '0;
   logic [CW-1:0] PERIOD_SAMPLES = '0;
   logic [NW-1:0] NUM_OF_IMP = '0;
   logic          SIGN_START_GEN = 1'b0;
   logic          ABORT = 1'b0;
   logic          OUT_REG_READY = 1'b1;
   logic [AW-1:0] ROM_ADDRESS;
   logic          SAMPLE_VALID;
   logic          GATE;
   logic          SIGN_START_CALC;
   logic          SIGN_STOP_CALC;
   logic          BUSY;
   logic          CFG_ERR;

   lfm_phase_accum_gen dut (
      .CLK             (CLK),
      .RESET_N         (RESET_N),
      .SIGNAL_MODE     (SIGNAL_MODE),
      .FREQ_START      (FREQ_START),
      .FREQ_STEP       (FREQ_STEP),
      .IMP_SAMPLES     (IMP_SAMPLES),
      .PERIOD_SAMPLES  (PERIOD_SAMPLES),
      .NUM_OF_IMP      (NUM_OF_IMP),
      .SIGN_START_GEN  (SIGN_START_GEN),
      .ABORT           (ABORT),
      .OUT_REG_READY   (OUT_REG_READY),
      .ROM_ADDRESS     (ROM_ADDRESS),
      .SAMPLE_VALID    (SAMPLE_VALID),
      .GATE            (GATE),
      .SIGN_START_CALC (SIGN_START_CALC),
      .SIGN_STOP_CALC  (SIGN_STOP_CALC),
      .BUSY            (BUSY),
      .CFG_ERR         (CFG_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] fstart;
      logic [31:0] fstep;
      int          imp;
      int          period;
      int          nimp;
   } cfg_t;

   typedef struct {
      cfg_t c;
      int   n;
      int   addr[10];
      int   gate[10];
   } vec_t;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [14:0] exp_q[$];
   vec_t        vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   function automatic logic [18:0] all_outputs();
      return {ROM_ADDRESS, SAMPLE_VALID, GATE, SIGN_START_CALC, SIGN_STOP_CALC, BUSY, CFG_ERR};
   endfunction

   // frequency word in use for sample j of a pulse
   function automatic logic [31:0] model_freq(cfg_t c, int j);
      logic [31:0] jj;
      logic [31:0] h;
      jj = 32'(j);
      h  = 32'(c.imp / 2);
      case (c.mode)
         2'd0:    return c.fstart;
         2'd1:    return c.fstart + jj * c.fstep;
         2'd2:    return c.fstart - jj * c.fstep;
         default: return (jj <= h) ? c.fstart + jj * c.fstep
                                    : c.fstart + h * c.fstep - (jj - h) * c.fstep;
      endcase
   endfunction

   function automatic void build_model(cfg_t c);
      int pe;
      int total;
      int k;
      logic [31:0] ph;
      logic [11:0] a;
      logic g;
      exp_q.delete();
      pe = (c.period > c.imp) ? c.period : c.imp;
      total = (c.nimp - 1) * pe + c.imp;
      for (int n = 0; n < total; n++) begin
         k = n % pe;
         if (k < c.imp) begin
            ph = '0;
            for (int j = 0; j < k; j++) ph = ph + model_freq(c, j);
            a = ph[31:20];
            g = 1'b1;
         end else begin
            a = '0;
            g = 1'b0;
         end
         exp_q.push_back({a, g, 1'(n == 0), 1'(n == total - 1)});
      end
   endfunction

   function automatic void build_table(int v);
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++)
         exp_q.push_back({12'(vecs[v].addr[i]), 1'(vecs[v].gate[i]), 1'(i == 0), 1'(i == vecs[v].n - 1)});
   endfunction

   task automatic apply_cfg(input cfg_t c);
      SIGNAL_MODE    = c.mode;
      FREQ_START     = c.fstart;
      FREQ_STEP      = c.fstep;
      IMP_SAMPLES    = CW'(c.imp);
      PERIOD_SAMPLES = CW'(c.period);
      NUM_OF_IMP     = NW'(c.nimp);
   endtask

   // ready_mode: 0 always ready, 1 random ready, 2 three-cycle stall on the third sample
   task automatic run_burst(input cfg_t c, input int ready_mode, input string tag);
      int total;
      int idx;
      int first_n;
      int stall_left;
      int idx2_obs;
      bit done;
      bit prev_stall;
      bit r;
      logic [18:0] snap;
      total = exp_q.size();
      idx = 0; first_n = -1; stall_left = 3; idx2_obs = 0;
      done = 0; prev_stall = 0; snap = '0;
      @(negedge CLK);
      apply_cfg(c);
      SIGN_START_GEN = 1'b1;
      OUT_REG_READY  = 1'b1;
      for (int n = 1; n < 3000 && !done; n++) begin
         @(negedge CLK);
         if (n == 1) begin
            SIGN_START_GEN = 1'b0;
            // configuration must be latched at start, so scribble over it
            FREQ_START  = $urandom;
            FREQ_STEP   = $urandom;
            SIGNAL_MODE = 2'($urandom);
         end
         if (prev_stall) check({tag, " stall_hold"}, all_outputs(), snap);
         if (SAMPLE_VALID) begin
            if (first_n < 0) begin
               first_n = n;
               check({tag, " first_valid_latency"}, n, 3);
            end
            if (ready_mode == 1) r = ($urandom % 10) < 7;
            else if (ready_mode == 2 && idx == 2 && stall_left > 0) begin
               r = 1'b0;
               stall_left--;
            end else r = 1'b1;
            OUT_REG_READY = r;
            if (idx == 2) idx2_obs++;
            if (r) begin
               check($sformatf("%s sample%0d {addr,gate,start,stop}", tag, idx),
                     {ROM_ADDRESS, GATE, SIGN_START_CALC, SIGN_STOP_CALC}, exp_q[idx]);
               idx++;
               if (idx == total) done = 1;
            end
            prev_stall = !r;
            snap = all_outputs();
         end else begin
            OUT_REG_READY = (ready_mode == 1) ? 1'($urandom) : 1'b1;
            prev_stall = 0;
         end
      end
      if (!done) check({tag, " samples_before_timeout"}, idx, total);
      @(negedge CLK);
      check({tag, " end {valid,busy}"}, {SAMPLE_VALID, BUSY}, 2'b00);
      if (ready_mode == 2) check({tag, " stalled_sample_cycles"}, idx2_obs, 4);
      OUT_REG_READY = 1'b1;
      $display("burst %s: %0d of %0d samples accepted", tag, idx, total);
   endtask

   initial begin
      cfg_t cw;
      cfg_t rc;

      vecs[0].c = '{2'd0, 32'h1000_0000, 32'h0, 4, 6, 2};
      vecs[0].n = 10;
      vecs[0].addr = '{0, 256, 512, 768, 0, 0, 0, 256, 512, 768};
      vecs[0].gate = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
      vecs[1].c = '{2'd1, 32'h0, 32'h0010_0000, 6, 0, 1};
      vecs[1].n = 6;
      vecs[1].addr = '{0, 0, 1, 3, 6, 10, 0, 0, 0, 0};
      vecs[1].gate = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      vecs[2].c = '{2'd3, 32'h0, 32'h0010_0000, 6, 0, 1};
      vecs[2].n = 6;
      vecs[2].addr = '{0, 0, 1, 3, 6, 8, 0, 0, 0, 0};
      vecs[2].gate = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      vecs[3].c = '{2'd0, 32'h1000_0000, 32'h0, 1, 0, 1};
      vecs[3].n = 1;
      vecs[3].addr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3].gate = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[4].c = '{2'd0, 32'h1000_0000, 32'h0, 3, 1, 2};
      vecs[4].n = 6;
      vecs[4].addr = '{0, 256, 512, 0, 256, 512, 0, 0, 0, 0};
      vecs[4].gate = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      vecs[5].c = '{2'd2, 32'h0040_0000, 32'h0010_0000, 4, 0, 1};
      vecs[5].n = 4;
      vecs[5].addr = '{0, 4, 7, 9, 0, 0, 0, 0, 0, 0};
      vecs[5].gate = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      cw = vecs[0].c;

      // reset state
      repeat (2) @(negedge CLK);
      check("in_reset outputs", all_outputs(), 19'h0);
      RESET_N = 1'b1;
      @(negedge CLK);
      check("after_reset outputs", all_outputs(), 19'h0);

      for (int v = 0; v < 6; v++) begin
         build_table(v);
         run_burst(vecs[v].c, 0, $sformatf("vec%0d", v));
      end
      build_table(0);
      run_burst(cw, 2, "cw_backpressure");

      // rejected starts
      for (int e = 0; e < 2; e++) begin
         @(negedge CLK);
         apply_cfg(cw);
         if (e == 0) IMP_SAMPLES = '0;
         else NUM_OF_IMP = '0;
         SIGN_START_GEN = 1'b1;
         @(negedge CLK);
         SIGN_START_GEN = 1'b0;
         check($sformatf("cfg_err%0d {err,busy}", e), {CFG_ERR, BUSY}, 2'b10);
         @(negedge CLK);
         check($sformatf("cfg_err%0d_after {err,busy,valid}", e), {CFG_ERR, BUSY, SAMPLE_VALID}, 3'b000);
      end

      // abort mid-burst, then a clean restart
      @(negedge CLK);
      apply_cfg(cw);
      SIGN_START_GEN = 1'b1;
      @(negedge CLK);
      SIGN_START_GEN = 1'b0;
      repeat (5) @(negedge CLK);
      check("pre_abort {valid,busy}", {SAMPLE_VALID, BUSY}, 2'b11);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      check("abort outputs", all_outputs(), 19'h0);
      build_table(0);
      run_burst(cw, 0, "cw_after_abort");

      // randomized bursts against the model
      for (int t = 0; t < 10; t++) begin
         rc.mode   = 2'($urandom);
         rc.fstart = $urandom;
         rc.fstep  = $urandom;
         rc.imp    = $urandom_range(1, 12);
         rc.period = $urandom_range(0, 16);
         rc.nimp   = $urandom_range(1, 3);
         build_model(rc);
         run_burst(rc, 1, $sformatf("rand%0d_m%0d", t, rc.mode));
      end

      // asynchronous reset in the middle of a burst
      @(negedge CLK);
      apply_cfg(cw);
      SIGN_START_GEN = 1'b1;
      @(negedge CLK);
      SIGN_START_GEN = 1'b0;
      repeat (4) @(negedge CLK);
      check("pre_reset {valid,busy}", {SAMPLE_VALID, BUSY}, 2'b11);
      @(posedge CLK);
      #2 RESET_N = 1'b0;
      #1 check("async_reset outputs", all_outputs(), 19'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      check("post_async_reset outputs", all_outputs(), 19'h0);
      build_table(0);
      run_burst(cw, 0, "cw_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lfm_phase_accum_gen.md
Name: lfm_phase_accum_gen

Overview:
Parametrised successor to the LFM phase accumulator: a fixed-point DDS phase/frequency accumulator that generates a burst of NUM_OF_IMP radio pulses. Each pulse is CW, up-chirp, down-chirp or symmetric (up then down); gaps between pulses output address 0. Frequency and chirp rate arrive as pre-scaled tuning words, so no divider is needed. It sits between the control/config block and the sine ROM, and drives the ROM address plus stream-control flags toward the output register.

Parameters:
PHASE_W, 32, phase/frequency accumulator width (modulo 2^PHASE_W)
ADDR_W, 12, ROM address width = top ADDR_W bits of phase
CNT_W, 27, width of sample counters (IMP_SAMPLES, PERIOD_SAMPLES)
NIMP_W, 5, width of NUM_OF_IMP
DITHER_W, 8, LFSR dither width (only used with the optional feature)

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
SIGNAL_MODE  in  2  0 CW, 1 LFM up, 2 LFM down, 3 LFM symmetric
FREQ_START  in  PHASE_W  initial frequency word per pulse
FREQ_STEP  in  PHASE_W  chirp increment per sample (unsigned magnitude)
IMP_SAMPLES  in  CNT_W  samples per pulse
PERIOD_SAMPLES  in  CNT_W  samples per repetition period
NUM_OF_IMP  in  NIMP_W  pulses per burst
SIGN_START_GEN  in  1  start request (level or pulse)
ABORT  in  1  synchronous abort
OUT_REG_READY  in  1  downstream accepts current sample
ROM_ADDRESS  out  ADDR_W  registered ROM address
SAMPLE_VALID  out  1  ROM_ADDRESS valid this cycle
GATE  out  1  1 inside pulse, 0 in gap
SIGN_START_CALC  out  1  high with first sample of burst
SIGN_STOP_CALC  out  1  high with last sample of burst
BUSY  out  1  burst in progress
CFG_ERR  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (async, RESET_N=0): state IDLE; all outputs 0; all counters and accumulators 0.
- States: IDLE -> LOAD -> RUN -> IDLE. ABORT in any state -> IDLE next cycle, outputs forced to reset values (ABORT takes priority over everything except reset).
- IDLE: SIGN_START_GEN=1 -> latch all config inputs. If IMP_SAMPLES==0 or NUM_OF_IMP==0: pulse CFG_ERR and stay in IDLE. Otherwise go to LOAD and set BUSY=1. Inputs are ignored while BUSY.
- Effective period = max(PERIOD_SAMPLES, IMP_SAMPLES); a shorter period means no gap.
- LOAD (1 cycle): phase=0, freq=FREQ_START, sample index k=0, pulse counter=0.
- Latency: start accepted at cycle t -> first SAMPLE_VALID at t+2, address 0, SIGN_START_CALC=1 for that sample only.
- RUN, each advance (an advance happens when SAMPLE_VALID=0 or OUT_REG_READY=1):
  - In pulse (k<IMP): ROM_ADDRESS = phase[PHASE_W-1 -: ADDR_W], GATE=1; then phase += freq.
  - Frequency update: mode 1 freq += STEP; mode 2 freq -= STEP; mode 0 unchanged; mode 3 += STEP when k < floor(IMP/2), else -= STEP.
  - In gap: ROM_ADDRESS=0, GATE=0; accumulators frozen.
  - At the period end: k=0, phase=0, freq=FREQ_START (coherent restart for each pulse), pulse counter +1.
- Stall: SAMPLE_VALID=1 and OUT_REG_READY=0 -> hold every output and all internal state.
- Burst length = (NUM_OF_IMP-1)*period + IMP_SAMPLES. The last pulse has no trailing gap.
- The last sample carries SIGN_STOP_CALC=1. After it is accepted: SAMPLE_VALID=0, BUSY=0, back to IDLE. A new start is accepted on the next cycle.
- Arithmetic: all adds and subtracts wrap modulo 2^PHASE_W; frequency underflow in down mode wraps silently (caller's responsibility).
- If NUM_OF_IMP==1 and IMP_SAMPLES==1, SIGN_START_CALC and SIGN_STOP_CALC are both high on the same sample.

Optional Feature:
LFM_PHASE_DITHER_EN
- Defined: a free-running DITHER_W-bit maximal LFSR (seed 1 at reset, advances every cycle) is added to phase bits [PHASE_W-ADDR_W-1 -: DITHER_W] before truncation. This affects the address only, never the accumulator. Gap addresses stay 0.
- Undefined: plain truncation; no LFSR logic is present.

Test Plan:
- CW: PHASE_W=32, ADDR_W=12, FREQ_START=2^28, IMP=4, PERIOD=6, N=2 -> addresses 0,256,512,768,0,0,0,256,512,768; GATE 1111001111; START on sample 1, STOP on sample 10, BUSY low afterwards.
- LFM up: FREQ_START=0, STEP=2^20, IMP=6, N=1 -> addresses 0,0,1,3,6,10.
- Symmetric: same as LFM up but SIGNAL_MODE=3 -> addresses 0,0,1,3,6,8.
- Backpressure: in the CW case, hold OUT_REG_READY=0 for 3 cycles at sample 3 -> address 512 held for 4 cycles, then the sequence continues unchanged and the total accepted samples still equal 10.
- Errors/abort: start with IMP_SAMPLES=0 -> CFG_ERR single pulse, BUSY stays 0. Assert ABORT mid-burst -> next cycle all outputs 0, IDLE. A new start then reproduces the CW sequence from address 0.
- Reset mid-burst: drop RESET_N asynchronously between clock edges -> outputs 0 immediately, without waiting for a clock edge.
